// File: rtl/io_pred_pkg.sv
// io_pred_pkg
//   Shared definitions for the I/O predication checker.
//   EF_EMPTY / EF_FULL : encodings of a port's Empty/Full status bit
//   clog2()            : ceiling log2, used to size index fields
package io_pred_pkg;

  localparam logic EF_EMPTY = 1'b0;
  localparam logic EF_FULL  = 1'b1;

  // Returns the number of bits needed to index 'value' items (minimum 0).
  function automatic int clog2(input int value);
    int width;
    int remaining;
    width     = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      width     = width + 1;
      remaining = remaining >> 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/io_check_multi_if.sv
// io_check_multi_if
//   Groups the instruction-side inputs and the registered result outputs
//   of io_check_multi.
//   master : instruction source (drives enable, thread_id, addr, channel_en,
//            port_EF, counters_clear; observes the results)
//   slave  : the checker (consumes the instruction, drives port_EF_masked,
//            addr_is_IO, io_ready, out_valid, out_thread_id, stall_count,
//            starved)
interface io_check_multi_if
  import io_pred_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int CHANNEL_COUNT = 3,
  parameter int PORT_COUNT    = 8,
  parameter int THREAD_WIDTH  = 3,
  parameter int STALL_WIDTH   = 4
);

  logic                                enable;
  logic [THREAD_WIDTH-1:0]             thread_id;
  logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] addr;
  logic [CHANNEL_COUNT-1:0]            channel_en;
  logic [CHANNEL_COUNT*PORT_COUNT-1:0] port_EF;
  logic                                counters_clear;

  logic [CHANNEL_COUNT-1:0]            port_EF_masked;
  logic [CHANNEL_COUNT-1:0]            addr_is_IO;
  logic                                io_ready;
  logic                                out_valid;
  logic [THREAD_WIDTH-1:0]             out_thread_id;
  logic [STALL_WIDTH-1:0]              stall_count;
  logic                                starved;

  modport master (
    output enable, thread_id, addr, channel_en, port_EF, counters_clear,
    input  port_EF_masked, addr_is_IO, io_ready, out_valid, out_thread_id,
           stall_count, starved
  );

  modport slave (
    input  enable, thread_id, addr, channel_en, port_EF, counters_clear,
    output port_EF_masked, addr_is_IO, io_ready, out_valid, out_thread_id,
           stall_count, starved
  );

endinterface

// File: rtl/io_check_channel.sv
// io_check_channel
//   Two-stage I/O address check for a single operand channel.
//   clock, reset     : rising-edge clock, async active-high reset
//   enable           : instruction valid
//   channel_en       : this channel's operand is used
//   addr             : operand address
//   port_ef          : Empty/Full bits of this channel's ports
//   ef_masked_next   : combinational stage-2 value of the masked EF bit
//   addr_is_io       : registered hit (stage 2)
//   ef_masked        : registered masked EF bit (stage 2)
module io_check_channel
  import io_pred_pkg::*;
#(
  parameter int   ADDR_WIDTH      = 10,
  parameter int   PORT_COUNT      = 8,
  parameter int   PORT_BASE_ADDR  = 1016,
  parameter int   PORT_ADDR_WIDTH = 3,
  parameter logic READY_BIT       = EF_FULL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  channel_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [PORT_COUNT-1:0] port_ef,
  output logic                  ef_masked_next,
  output logic                  addr_is_io,
  output logic                  ef_masked
);

  logic                       in_window;
  logic                       hit_now;
  logic [PORT_ADDR_WIDTH-1:0] port_index;
  logic                       hit_q;
  logic                       ef_q;

  // The window test is done in 32 bits so a window end that would wrap
  // past 2^ADDR_WIDTH never makes small addresses look like I/O.
  always_comb begin
    in_window  = (32'(addr) >= 32'(PORT_BASE_ADDR)) &&
                 (32'(addr) <= 32'(PORT_BASE_ADDR + PORT_COUNT - 1));
    hit_now    = enable & channel_en & in_window;
    port_index = PORT_ADDR_WIDTH'(addr - ADDR_WIDTH'(PORT_BASE_ADDR));
  end

  // Unused or non-I/O channels report their ready value so they never
  // block the instruction.
  always_comb begin
    ef_masked_next = hit_q ? ef_q : READY_BIT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_q      <= 1'b0;
      ef_q       <= 1'b0;
      addr_is_io <= 1'b0;
      ef_masked  <= 1'b0;
    end else begin
      hit_q      <= hit_now;
      ef_q       <= port_ef[port_index];
      addr_is_io <= hit_q;
      ef_masked  <= ef_masked_next;
    end
  end

endmodule

// File: rtl/io_check_multi.sv
// io_check_multi
//   Checks the A/B read and D write operand addresses of an instruction
//   against the memory-mapped I/O window and reports whether every touched
//   port is ready, with per-thread stall counting and starvation flag.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : slave side of io_check_multi_if (instruction in,
//                  registered results out, two-cycle latency)
module io_check_multi
  import io_pred_pkg::*;
#(
  parameter int                       ADDR_WIDTH      = 10,
  parameter int                       CHANNEL_COUNT   = 3,
  parameter int                       PORT_COUNT      = 8,
  parameter int                       PORT_BASE_ADDR  = 1016,
  parameter int                       PORT_ADDR_WIDTH = 3,
  parameter logic [CHANNEL_COUNT-1:0] READY_STATE     = 3'b011,
  parameter int                       THREAD_COUNT    = 8,
  parameter int                       THREAD_WIDTH    = 3,
  parameter int                       STALL_WIDTH     = 4,
  parameter int                       STARVE_LIMIT    = 15
) (
  input logic             clock,
  input logic             reset,
  io_check_multi_if.slave bus
);

  localparam int ThreadSelWidth = (THREAD_COUNT > 1) ? clog2(THREAD_COUNT) : 1;

  logic [CHANNEL_COUNT-1:0] masked_next;
  logic [CHANNEL_COUNT-1:0] masked_q;
  logic [CHANNEL_COUNT-1:0] is_io_q;
  logic                     ready_next;

  logic                     valid_q;
  logic [THREAD_WIDTH-1:0]  thread_q;

  logic [STALL_WIDTH-1:0]   stall_counters [THREAD_COUNT];
  logic [STALL_WIDTH-1:0]   stall_current;
  logic [STALL_WIDTH-1:0]   stall_next;
  logic                     starved_next;

  logic                     out_valid_q;
  logic [THREAD_WIDTH-1:0]  out_thread_q;
  logic                     io_ready_q;
  logic [STALL_WIDTH-1:0]   stall_count_q;
  logic                     starved_q;

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_channel
    io_check_channel #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .PORT_COUNT      (PORT_COUNT),
      .PORT_BASE_ADDR  (PORT_BASE_ADDR),
      .PORT_ADDR_WIDTH (PORT_ADDR_WIDTH),
      .READY_BIT       (READY_STATE[c])
    ) u_channel (
      .clock          (clock),
      .reset          (reset),
      .enable         (bus.enable),
      .channel_en     (bus.channel_en[c]),
      .addr           (bus.addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .port_ef        (bus.port_EF[c*PORT_COUNT +: PORT_COUNT]),
      .ef_masked_next (masked_next[c]),
      .addr_is_io     (is_io_q[c]),
      .ef_masked      (masked_q[c])
    );
  end

  // Counters are only read in stage 2, one edge after the previous
  // instruction wrote them, so back-to-back instructions of one thread
  // always see the up-to-date count without forwarding.
  always_comb begin
    ready_next    = &(masked_next ~^ READY_STATE);
    stall_current = stall_counters[thread_q[ThreadSelWidth-1:0]];
    if (ready_next) begin
      stall_next = '0;
    end else if (&stall_current) begin
      stall_next = stall_current;
    end else begin
      stall_next = stall_current + STALL_WIDTH'(1);
    end
    starved_next = 32'(stall_next) >= 32'(STARVE_LIMIT);
  end

  // Stage 1 captures the instruction tag; stage 2 updates the owning
  // thread's counter and registers the results. A clear wins over the
  // same-edge update, yet the outputs still show the updated count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      thread_q      <= '0;
      out_valid_q   <= 1'b0;
      out_thread_q  <= '0;
      io_ready_q    <= 1'b0;
      stall_count_q <= '0;
      starved_q     <= 1'b0;
      for (int t = 0; t < THREAD_COUNT; t++) begin
        stall_counters[t] <= '0;
      end
    end else begin
      valid_q       <= bus.enable;
      thread_q      <= bus.thread_id;
      out_valid_q   <= valid_q;
      out_thread_q  <= thread_q;
      io_ready_q    <= valid_q & ready_next;
      stall_count_q <= valid_q ? stall_next : '0;
      starved_q     <= valid_q & starved_next;
      if (bus.counters_clear) begin
        for (int t = 0; t < THREAD_COUNT; t++) begin
          stall_counters[t] <= '0;
        end
      end else if (valid_q) begin
        stall_counters[thread_q[ThreadSelWidth-1:0]] <= stall_next;
      end
    end
  end

  assign bus.port_EF_masked = masked_q;
  assign bus.addr_is_IO     = is_io_q;
  assign bus.io_ready       = io_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_thread_id  = out_thread_q;
  assign bus.stall_count    = stall_count_q;
  assign bus.starved        = starved_q;

endmodule

// File: doc/io_check_multi.md
IO_CHECK_MULTI -- requirements
Module: io_check_multi

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, operand address width.
REQ-002 SHALL have parameter CHANNEL_COUNT, default 3, number of address channels checked in parallel (A read, B read, D write).
REQ-003 SHALL have parameter PORT_COUNT, default 8, I/O ports per channel.
REQ-004 SHALL have parameter PORT_BASE_ADDR, default 1016, first I/O address, common to all channels.
REQ-005 SHALL have parameter PORT_ADDR_WIDTH, default 3, port index width.
REQ-006 SHALL have parameter READY_STATE, default 3'b011, CHANNEL_COUNT bits: per-channel ready value (1 = FULL for reads, 0 = EMPTY for writes).
REQ-007 SHALL have parameters THREAD_COUNT 8, THREAD_WIDTH 3, STALL_WIDTH 4 and STARVE_LIMIT 15.
REQ-008 SHALL have port clock, in, 1, single clock; all state on rising edge.
REQ-009 SHALL have port reset, in, 1, asynchronous, active-high.
REQ-010 SHALL have ports enable (in, 1, instruction valid) and thread_id (in, THREAD_WIDTH).
REQ-011 SHALL have port addr, in, CHANNEL_COUNT*ADDR_WIDTH; channel c occupies slice c.
REQ-012 SHALL have port channel_en, in, CHANNEL_COUNT, marks a channel's operand as used.
REQ-013 SHALL have port port_EF, in, CHANNEL_COUNT*PORT_COUNT, Empty/Full bits per channel.
REQ-014 SHALL have port counters_clear, in, 1, synchronous clear of all stall counters.
REQ-015 SHALL have outputs port_EF_masked (CHANNEL_COUNT), addr_is_IO (CHANNEL_COUNT), io_ready (1), out_valid (1), out_thread_id (THREAD_WIDTH), stall_count (STALL_WIDTH) and starved (1), all registered.

Function
REQ-016 Channel c SHALL hit when enable & channel_en[c] & PORT_BASE_ADDR <= addr_c <= PORT_BASE_ADDR+PORT_COUNT-1.
REQ-017 Port index SHALL be addr_c - PORT_BASE_ADDR, truncated to PORT_ADDR_WIDTH; selected bit = port_EF[c*PORT_COUNT+index].
REQ-018 Stage 1 (edge E1 after input) SHALL register per-channel hit and selected EF, plus enable and thread_id.
REQ-019 Stage 2 (edge E2) SHALL register addr_is_IO[c] = hit[c] and port_EF_masked[c] = hit[c] ? EF[c] : READY_STATE[c]; total latency 2 cycles.
REQ-020 Stage 2 SHALL register io_ready = AND over c of (port_EF_masked[c] == READY_STATE[c]); disabled and non-I/O channels count as ready.
REQ-021 out_valid and out_thread_id SHALL be the stage-1 enable and thread_id delayed to E2.
REQ-022 Each thread SHALL own a STALL_WIDTH counter; at E2, if stage-1 valid: !io_ready increments it, saturating at all-ones; io_ready clears it.
REQ-023 If stage-1 is not valid, no counter SHALL change.
REQ-024 stall_count SHALL show the post-update value of that thread's counter; starved = valid & (post-update count >= STARVE_LIMIT).
REQ-025 When out_valid = 0, io_ready, stall_count and starved SHALL be 0.
REQ-026 Back-to-back instructions of the same thread SHALL see the counter as updated by the previous one, with no hazard.
REQ-027 counters_clear SHALL zero all counters at the next edge and take priority over an update in the same cycle; the registered outputs of that cycle still show the pre-clear update.
REQ-028 An address beyond the window, including wrap of PORT_BASE_ADDR+PORT_COUNT past 2^ADDR_WIDTH, SHALL never hit.

Reset
REQ-029 reset SHALL asynchronously clear all pipeline registers, counters and outputs to 0.
REQ-030 A reset mid-pipeline SHALL discard in-flight instructions; no output goes valid until two edges after reset deasserts with enable = 1.

Structure
REQ-031 Package io_pred_pkg SHALL hold EF_EMPTY = 0, EF_FULL = 1 and a clog2 function for widths.
REQ-032 Sub-module io_check_channel SHALL implement REQ-016 to REQ-019 for one channel, instantiated CHANNEL_COUNT times.
REQ-033 Counters, readiness reduction and output registers SHALL live in io_check_multi.

Verification
REQ-034 Bench SHALL drive all addr = 5, channel_en = 3'b111 -> after 2 cycles: addr_is_IO = 000, port_EF_masked = 011, io_ready = 1, stall_count = 0.
REQ-035 Bench SHALL drive ch0 addr = 1018, port_EF ch0 bit2 = 0 -> addr_is_IO[0] = 1, masked[0] = 0, io_ready = 0, and thread's stall_count increments by 1.
REQ-036 Bench SHALL stall thread 2 for 16 consecutive instructions -> stall_count 15 and starved = 1 on the 15th and 16th; then one ready instruction -> stall_count = 0, starved = 0.
REQ-037 Bench SHALL drive ch2 (write) addr = 1023, EF = 1, then EF = 0 -> io_ready = 0, then 1; addr 1024 mod 2^10 = 0 -> no hit.
REQ-038 Bench SHALL assert reset with valid instructions in both stages -> all outputs 0 immediately; assert counters_clear together with a stall -> output shows incremented count, next read of that thread shows 1 only if stalled again.
